// File: rtl/alu_pkg.sv
// Shared ALU encodings: function codes, branch condition codes and the
// bit layout of the architectural status register.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_POS    = 3'd3,
    BR_NEG    = 3'd4,
    BR_CS     = 3'd5,
    BR_CC     = 3'd6,
    BR_VS     = 3'd7
  } branch_cond_e;

  localparam int STATUS_W = 4;
  localparam int Z_BIT    = 0;
  localparam int P_BIT    = 1;
  localparam int C_BIT    = 2;
  localparam int V_BIT    = 3;

  function automatic logic func_is_legal(input logic [2:0] f);
    return f <= 3'(ALU_INV);
  endfunction

  // Only the arithmetic functions produce meaningful carry/overflow.
  function automatic logic func_sets_cv(input logic [2:0] f);
    return (f == 3'(ALU_ADD)) || (f == 3'(ALU_SUB));
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Registered write-back queue with valid/ready on both sides. Storage is not
// reset; the output is forced to zero while the queue is empty.
module wb_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // No pop bypass: a full queue refuses captures even if it pops this cycle.
  assign push_ready = count < CNT_W'(DEPTH);
  assign pop_valid  = count != '0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU consumer: captures result/flags, maintains the status register,
// resolves branch conditions and queues results for register write-back.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_IDX_W  = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_valid,
  output logic                 cap_ready,
  input  logic [2:0]           alu_func,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 zero_flag,
  input  logic                 positive_flag,
  input  logic                 carry_flag,
  input  logic                 signed_overflow,
  input  logic [REG_IDX_W-1:0] cap_dest,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [DATA_W-1:0]    wb_data,
  output logic [REG_IDX_W-1:0] wb_dest,
  output logic [STATUS_W-1:0]  status_flags,
  input  logic [2:0]           branch_cond,
  output logic                 branch_taken,
  output logic                 err_illegal_func
);

  localparam int ENTRY_W = DATA_W + REG_IDX_W;

  logic               cap_fire;
  logic               func_legal;
  logic [STATUS_W-1:0] status_q;
  logic               err_q;
  logic [ENTRY_W-1:0] entry_head;

  assign func_legal = func_is_legal(alu_func);
  assign cap_fire   = cap_valid && cap_ready;

  wb_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (cap_valid && func_legal),
    .push_ready (cap_ready),
    .push_data  ({alu_result, cap_dest}),
    .pop_valid  (wb_valid),
    .pop_ready  (wb_ready),
    .pop_data   (entry_head)
  );

  assign {wb_data, wb_dest} = entry_head;

  // Status register and sticky illegal-function error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      err_q    <= 1'b0;
    end else if (cap_fire) begin
      if (func_legal) begin
        status_q[Z_BIT] <= zero_flag;
        status_q[P_BIT] <= positive_flag;
        if (func_sets_cv(alu_func)) begin
          status_q[C_BIT] <= carry_flag;
          status_q[V_BIT] <= signed_overflow;
        end
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign status_flags     = status_q;
  assign err_illegal_func = err_q;

  always_comb begin
    branch_taken = 1'b0;
    case (branch_cond_e'(branch_cond))
      BR_ALWAYS: branch_taken = 1'b1;
      BR_EQ:     branch_taken = status_q[Z_BIT];
      BR_NE:     branch_taken = !status_q[Z_BIT];
      BR_POS:    branch_taken = status_q[P_BIT];
      BR_NEG:    branch_taken = !status_q[P_BIT];
      BR_CS:     branch_taken = status_q[C_BIT];
      BR_CC:     branch_taken = !status_q[C_BIT];
      BR_VS:     branch_taken = status_q[V_BIT];
      default:   branch_taken = 1'b0;
    endcase
  end

  // The ALU may leave C/V undriven for logic ops, but never result, Z or P.
  a_known_capture : assert property (@(posedge clk) disable iff (reset)
    (cap_fire && func_legal) |-> !$isunknown({alu_result, zero_flag, positive_flag}));

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cap_valid;
  logic       cap_ready;
  logic [2:0] alu_func;
  logic [7:0] alu_result;
  logic       zero_flag, positive_flag, carry_flag, signed_overflow;
  logic [2:0] cap_dest;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [2:0] wb_dest;
  logic [3:0] status_flags;
  logic [2:0] branch_cond;
  logic       branch_taken;
  logic       err_illegal_func;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(8), .REG_IDX_W(3), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .cap_valid        (cap_valid),
    .cap_ready        (cap_ready),
    .alu_func         (alu_func),
    .alu_result       (alu_result),
    .zero_flag        (zero_flag),
    .positive_flag    (positive_flag),
    .carry_flag       (carry_flag),
    .signed_overflow  (signed_overflow),
    .cap_dest         (cap_dest),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_data          (wb_data),
    .wb_dest          (wb_dest),
    .status_flags     (status_flags),
    .branch_cond      (branch_cond),
    .branch_taken     (branch_taken),
    .err_illegal_func (err_illegal_func)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cap(input logic [2:0] f, input logic [7:0] r, input logic z, input logic p,
                         input logic c, input logic v, input logic [2:0] d);
    alu_func = f; alu_result = r; zero_flag = z; positive_flag = p;
    carry_flag = c; signed_overflow = v; cap_dest = d; cap_valid = 1'b1;
  endtask

  // One-cycle capture, starting and ending on a falling edge.
  task automatic cap(input logic [2:0] f, input logic [7:0] r, input logic z, input logic p,
                     input logic c, input logic v, input logic [2:0] d);
    set_cap(f, r, z, p, c, v, d);
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic [2:0] idx);
    check({tag, "_vld"}, 32'(wb_valid), 32'd1);
    check({tag, "_data"}, 32'(wb_data), 32'(d));
    check({tag, "_dest"}, 32'(wb_dest), 32'(idx));
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  task automatic br_check(input string tag, input logic [2:0] cond, input logic exp);
    branch_cond = cond;
    #1;
    check(tag, 32'(branch_taken), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; cap_valid = 1'b0; wb_ready = 1'b0; branch_cond = 3'(BR_ALWAYS);
    alu_func = 3'd0; alu_result = 8'h00; zero_flag = 1'b0; positive_flag = 1'b0;
    carry_flag = 1'b0; signed_overflow = 1'b0; cap_dest = 3'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cap_ready", 32'(cap_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_dest", 32'(wb_dest), 32'd0);
    check("rst_status", 32'(status_flags), 32'd0);
    check("rst_err", 32'(err_illegal_func), 32'd0);
    br_check("rst_br_always", 3'(BR_ALWAYS), 1'b1);
    br_check("rst_br_eq", 3'(BR_EQ), 1'b0);
    br_check("rst_br_ne", 3'(BR_NE), 1'b1);
    br_check("rst_br_cc", 3'(BR_CC), 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADD result 0, Z=1 C=1
    cap(3'(ALU_ADD), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
    check("add_status", 32'(status_flags), 32'b0101);
    br_check("add_br_eq", 3'(BR_EQ), 1'b1);
    br_check("add_br_cs", 3'(BR_CS), 1'b1);
    br_check("add_br_ne", 3'(BR_NE), 1'b0);
    pop_check("add_pop", 8'h00, 3'd3);
    check("add_empty", 32'(wb_valid), 32'd0);

    // SUB sets C,V; AND with undriven C/V keeps them
    cap(3'(ALU_SUB), 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
    check("sub_status", 32'(status_flags), 32'b1100);
    cap(3'(ALU_AND), 8'h05, 1'b0, 1'b1, 1'bx, 1'bx, 3'd2);
    check("and_status", 32'(status_flags), 32'b1110);
    br_check("and_br_vs", 3'(BR_VS), 1'b1);
    br_check("and_br_pos", 3'(BR_POS), 1'b1);
    check("full_cap_ready", 32'(cap_ready), 32'd0);
    pop_check("sub_pop", 8'h80, 3'd1);
    pop_check("and_pop", 8'h05, 3'd2);
    check("and_empty", 32'(wb_valid), 32'd0);

    // Backpressure: third capture held until space frees
    cap(3'(ALU_ADD), 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);
    check("bp_ready1", 32'(cap_ready), 32'd1);
    cap(3'(ALU_ADD), 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
    check("bp_ready2", 32'(cap_ready), 32'd0);
    set_cap(3'(ALU_ADD), 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6);
    @(negedge clk);
    check("bp_held_ready", 32'(cap_ready), 32'd0);
    check("bp_held_data", 32'(wb_data), 32'h11);
    check("bp_held_dest", 32'(wb_dest), 32'd4);
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_data", 32'(wb_data), 32'h22);
    check("bp_pop1_ready", 32'(cap_ready), 32'd1);
    @(negedge clk);
    cap_valid = 1'b0;
    check("bp_pop2_data", 32'(wb_data), 32'h33);
    check("bp_pop2_dest", 32'(wb_dest), 32'd6);
    check("bp_pop2_vld", 32'(wb_valid), 32'd1);
    @(negedge clk);
    wb_ready = 1'b0;
    check("bp_empty", 32'(wb_valid), 32'd0);
    check("bp_status", 32'(status_flags), 32'b0010);

    // Count 1: simultaneous capture and pop
    cap(3'(ALU_ADD), 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7);
    set_cap(3'(ALU_ADD), 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    wb_ready = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0;
    wb_ready = 1'b0;
    check("pp_ready", 32'(cap_ready), 32'd1);
    pop_check("pp_pop", 8'hBB, 3'd0);
    check("pp_empty", 32'(wb_valid), 32'd0);
    check("pp_status", 32'(status_flags), 32'b0110);

    // Illegal function: no push, no flag change, sticky error
    set_cap(3'd7, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    #1;
    check("ill_ready", 32'(cap_ready), 32'd1);
    @(negedge clk);
    cap_valid = 1'b0;
    check("ill_no_push", 32'(wb_valid), 32'd0);
    check("ill_status", 32'(status_flags), 32'b0110);
    check("ill_err", 32'(err_illegal_func), 32'd1);
    cap(3'(ALU_ADD), 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1);
    cap(3'(ALU_ADD), 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    check("ill_err_sticky", 32'(err_illegal_func), 32'd1);
    check("rq_status", 32'(status_flags), 32'b1110);
    check("rq_full", 32'(cap_ready), 32'd0);

    // Asynchronous reset with two queued entries
    #2 reset = 1'b1;
    #1;
    check("ar_wb_valid", 32'(wb_valid), 32'd0);
    check("ar_cap_ready", 32'(cap_ready), 32'd1);
    check("ar_status", 32'(status_flags), 32'd0);
    check("ar_err", 32'(err_illegal_func), 32'd0);
    check("ar_wb_data", 32'(wb_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_still_empty", 32'(wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Consumer side of the ALU: samples the ALU's tri-stated result bus and flag outputs when the datapath issues a capture, holds the status flags (Z, P, C, V) in an architectural status register, evaluates branch conditions against them, and queues results with their destination register index for write-back into the register file. Sits between the ALU output bus and the register-file write port, and feeds branch resolution in the fetch stage.

## Interface
- DATA_W, 8, width of ALU result and write-back data
- REG_IDX_W, 3, width of destination register index
- FIFO_DEPTH, 2, write-back queue entries (power of two, ≥2)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cap_valid  in  1  capture request; ALU output_enable is asserted this cycle
- cap_ready  out  1  block can accept a capture
- alu_func  in  3  function that produced the result (alu_pkg::alu_func_e)
- alu_result  in  DATA_W  ALU result bus
- zero_flag, positive_flag, carry_flag, signed_overflow  in  1 each  ALU flag outputs
- cap_dest  in  REG_IDX_W  destination register index
- wb_valid  out  1  write-back entry available
- wb_ready  in  1  register file accepts entry
- wb_data  out  DATA_W  head-of-queue result
- wb_dest  out  REG_IDX_W  head-of-queue destination
- status_flags  out  4  registered {V, C, P, Z}
- branch_cond  in  3  condition code (alu_pkg::branch_cond_e)
- branch_taken  out  1  condition true against status_flags
- err_illegal_func  out  1  sticky: capture seen with undefined alu_func

## Operation
- Capture fires on cap_valid && cap_ready. cap_ready = (count < FIFO_DEPTH); no same-cycle pop bypass when full.
- alu_func encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, INV 5; 6, 7 illegal.
- Legal capture: push {alu_result, cap_dest}; Z, P loaded from inputs; C, V loaded only for ADD/SUB, else retain previous values (ALU drives X for them).
- Illegal capture: handshake completes, no push, no flag update, err_illegal_func set until reset.
- Pop on wb_valid && wb_ready; wb_valid = (count != 0). Simultaneous push and pop when 0 < count < DEPTH: count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH; count is log2(DEPTH)+1 bits.
- branch_cond: ALWAYS 0, EQ 1 (Z), NE 2 (!Z), POS 3 (P), NEG 4 (!P), CS 5 (C), CC 6 (!C), VS 7 (V). branch_taken combinational from status_flags only.
- alu_result/flags never X/Z on a legal capture (assertion); C/V inputs ignored (may be X) for logic ops.

## Timing
- Reset values: cap_ready 1, wb_valid 0, wb_data/wb_dest 0, status_flags 4'b0000, branch_taken 1 if cond ALWAYS else per zero flags, err_illegal_func 0; queue emptied.
- Reset mid-operation: queued entries discarded, no partial write-back.
- Capture-to-wb_valid: 1 cycle (registered queue). Capture-to-status_flags: 1 cycle; branch on those flags resolvable the cycle after capture.
- wb_data/wb_dest stable while wb_valid && !wb_ready.

## Structure
- alu_pkg gains branch_cond_e (3-bit enum above) and STATUS_W = 4 plus bit-position constants Z_BIT 0, P_BIT 1, C_BIT 2, V_BIT 3; alu_func_e reused.
- One sub-module: wb_fifo (parameterised DATA width × DEPTH, valid/ready both sides); flag register, illegal-func detect and branch mux in top.

## Test plan
- Reset then ADD capture result 8'h00, Z=1,C=1,V=0, dest 3 -> next cycle wb_valid=1, wb_data 8'h00, wb_dest 3, status_flags 4'b0101, branch EQ and CS taken.
- SUB capture (C=1,V=1) then AND capture with C/V inputs X -> status C=1,V=1 retained, Z/P updated from AND.
- wb_ready=0, three back-to-back captures 8'h11, 8'h22, 8'h33 -> cap_ready drops after second; third held; release wb_ready -> pops 11, 22, then 33 accepted and popped in order.
- Count 1, capture and pop in same cycle -> count stays 1, order preserved across pointer wrap.
- Capture with alu_func 3'd7 -> no push, flags unchanged, err_illegal_func 1 until reset.
- Assert reset with two queued entries -> wb_valid 0, cap_ready 1, status_flags 0 immediately (asynchronous).
